if_stage: RTL and testbench



---
 rtl/if_stage_if.sv | 14 +
 rtl/if_stage.sv | 113 +++++++++++
 tb/tb_if_stage.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus: single-outstanding req/ack with word address and read data.
// Combinational bundle; the fetch stage is master, the memory is slave.
interface if_stage_if #(
    parameter int PC_WIDTH   = 30,
    parameter int INSN_WIDTH = 32
);
    logic                  req;
    logic [PC_WIDTH-1:0]   addr;
    logic                  ack;
    logic [INSN_WIDTH-1:0] rdata;

    modport master (output req, addr, input  ack, rdata);
    modport slave  (input  req, addr, output ack, rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: word PC, single-outstanding imem req/ack, registered if_* toward the decoder.
// Latency: ack cycle -> if_* valid next edge; one instruction per ack in steady state.
// Backpressure: stall freezes if_*, an ack taken during stall parks in a 1-entry skid (HOLD).
module if_stage #(
    parameter int                    PC_WIDTH   = 30,
    parameter int                    INSN_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0,
    parameter logic [INSN_WIDTH-1:0] NOP_INSN   = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  br_taken,
    input  logic [PC_WIDTH-1:0]   br_addr,
    if_stage_if.master            imem,
    output logic [PC_WIDTH-1:0]   if_pc,
    output logic [INSN_WIDTH-1:0] if_insn,
    output logic                  if_en
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [PC_WIDTH-1:0]   addr_q, addr_d;
    logic [PC_WIDTH-1:0]   skid_pc_q, skid_pc_d;
    logic [INSN_WIDTH-1:0] skid_insn_q, skid_insn_d;
    logic [PC_WIDTH-1:0]   if_pc_d;
    logic [INSN_WIDTH-1:0] if_insn_d;
    logic                  if_en_d;
    logic                  req_w;

    assign req_w     = (state_q == FETCH) || (state_q == DROP);
    assign imem.req  = req_w;
    assign imem.addr = addr_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        skid_pc_d   = skid_pc_q;
        skid_insn_d = skid_insn_q;
        if_pc_d     = if_pc;
        if_insn_d   = if_insn;
        if_en_d     = if_en;

        if (br_taken) begin
            // Redirect wins over stall and ack; an un-acked request must still be drained.
            pc_d      = br_addr;
            if_en_d   = 1'b0;
            if_insn_d = NOP_INSN;
            state_d   = (req_w && !imem.ack) ? DROP : FETCH;
        end else begin
            case (state_q)
                IDLE: state_d = FETCH;
                FETCH: begin
                    if (imem.ack) begin
                        pc_d = pc_q + PC_WIDTH'(1);
                        if (stall) begin
                            skid_pc_d   = pc_q;
                            skid_insn_d = imem.rdata;
                            state_d     = HOLD;
                        end else begin
                            if_pc_d   = pc_q;
                            if_insn_d = imem.rdata;
                            if_en_d   = 1'b1;
                        end
                    end else if (!stall) begin
                        if_en_d   = 1'b0;
                        if_insn_d = NOP_INSN;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_pc_d   = skid_pc_q;
                        if_insn_d = skid_insn_q;
                        if_en_d   = 1'b1;
                        state_d   = FETCH;
                    end
                end
                DROP: begin
                    if (imem.ack) state_d = FETCH;
                end
                default: state_d = IDLE;
            endcase
        end

        // The address register follows the PC except while draining a killed request.
        addr_d = (state_d == DROP) ? addr_q : pc_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            skid_pc_q   <= '0;
            skid_insn_q <= '0;
            if_pc       <= '0;
            if_insn     <= NOP_INSN;
            if_en       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            skid_pc_q   <= skid_pc_d;
            skid_insn_q <= skid_insn_d;
            if_pc       <= if_pc_d;
            if_insn     <= if_insn_d;
            if_en       <= if_en_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: random-latency memory responder, random stall/branch, and a
// stream model (sequential PCs with redirects) that every accepted instruction must match.
module tb_if_stage;
    localparam int             PW  = 30;
    localparam int             IW  = 32;
    localparam logic [IW-1:0]  NOP = 32'h0000_0013;
    localparam logic [PW-1:0]  RST_PC = '0;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          stall = 1'b0;
    logic          br_taken = 1'b0;
    logic [PW-1:0] br_addr = '0;
    logic [PW-1:0] if_pc;
    logic [IW-1:0] if_insn;
    logic          if_en;

    if_stage_if #(.PC_WIDTH(PW), .INSN_WIDTH(IW)) imem ();

    if_stage #(.PC_WIDTH(PW), .INSN_WIDTH(IW), .RESET_PC(RST_PC), .NOP_INSN(NOP)) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .br_taken (br_taken),
        .br_addr  (br_addr),
        .imem     (imem),
        .if_pc    (if_pc),
        .if_insn  (if_insn),
        .if_en    (if_en)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
        return 32'(a) + 32'h100;
    endfunction

    // Memory responder: acks after a random number of wait cycles per request.
    int min_lat = 0;
    int max_lat = 0;
    int lat_cnt = 0;
    bit inject_ack = 1'b0;

    initial begin
        imem.ack   = 1'b0;
        imem.rdata = '0;
    end

    always @(posedge clk) begin
        #1;
        if (inject_ack) begin
            imem.ack   = 1'b1;
            imem.rdata = 32'hDEAD_BEEF;
        end else if (!reset) begin
            imem.ack = 1'b0;
            lat_cnt  = 0;
        end else if (imem.req) begin
            if (lat_cnt == 0) begin
                imem.ack   = 1'b1;
                imem.rdata = mem_word(imem.addr);
                lat_cnt    = int'($urandom_range(max_lat, min_lat));
            end else begin
                imem.ack = 1'b0;
                lat_cnt--;
            end
        end else begin
            imem.ack = 1'b0;
        end
    end

    // Stream model: the decoder takes if_* at an edge where if_en=1 and stall=0.
    logic [PW-1:0] model_pc = RST_PC;
    int            consumed = 0;
    bit            pend = 1'b0;
    logic [PW-1:0] pend_addr = '0;

    always @(negedge clk) begin
        if (!reset) begin
            model_pc = RST_PC;
            pend     = 1'b0;
        end else begin
            if (pend) begin
                chk_eq("req_held_until_ack", 64'(imem.req), 64'(1));
                chk_eq("addr_stable_while_pending", 64'(imem.addr), 64'(pend_addr));
            end
            pend      = imem.req && !imem.ack;
            pend_addr = imem.addr;
            if (if_en && !stall) begin
                chk_eq("stream_pc", 64'(if_pc), 64'(model_pc));
                chk_eq("stream_insn", 64'(if_insn), 64'(mem_word(model_pc)));
                model_pc = model_pc + PW'(1);
                consumed++;
            end
            if (br_taken) model_pc = br_addr;
        end
    end

    task automatic wait_out(input logic [PW-1:0] pc, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (if_en && if_pc == pc) found = 1'b1;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_eq({tag, "_req"},   64'(imem.req),  64'(0));
        chk_eq({tag, "_addr"},  64'(imem.addr), 64'(RST_PC));
        chk_eq({tag, "_en"},    64'(if_en),     64'(0));
        chk_eq({tag, "_insn"},  64'(if_insn),   64'(NOP));
        chk_eq({tag, "_pc"},    64'(if_pc),     64'(0));
    endtask

    initial begin
        bit            found;
        int            pulses;
        logic [PW-1:0] snap_pc, old_addr, top;
        logic [IW-1:0] snap_insn;
        logic [31:0]   r;

        // Reset and zero-latency streaming.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b1;
        #1 chk_eq("req_low_after_release", 64'(imem.req), 64'(0));
        @(posedge clk); #3;
        chk_eq("req_rise", 64'(imem.req), 64'(1));
        chk_eq("first_addr", 64'(imem.addr), 64'(RST_PC));
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #3;
            chk_eq("seq_pc", 64'(if_pc), 64'(i));
            chk_eq("seq_insn", 64'(if_insn), 64'(32'h100 + i));
            chk_eq("seq_en", 64'(if_en), 64'(1));
        end

        // Fixed 3-cycle latency: one pulse every 4 cycles, NOP in the bubbles.
        min_lat = 3; max_lat = 3;
        repeat (8) @(posedge clk);
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (if_en) pulses++;
            else chk_eq("bubble_nop", 64'(if_insn), 64'(NOP));
        end
        chk_eq("pulse_count", 64'(pulses), 64'(4));

        // Stall over an ack: outputs frozen, skid entry appears on release.
        min_lat = 0; max_lat = 0;
        repeat (6) @(posedge clk);
        #2 stall = 1'b1;
        @(negedge clk);
        snap_pc = if_pc; snap_insn = if_insn;
        chk_eq("stall_en", 64'(if_en), 64'(1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_eq("stall_frozen_pc", 64'(if_pc), 64'(snap_pc));
            chk_eq("stall_frozen_insn", 64'(if_insn), 64'(snap_insn));
        end
        @(posedge clk); #2 stall = 1'b0;
        @(posedge clk); #3;
        chk_eq("stall_release_pc", 64'(if_pc), 64'(snap_pc + PW'(1)));
        @(posedge clk); #3;
        chk_eq("stall_next_pc", 64'(if_pc), 64'(snap_pc + PW'(2)));

        // Branch while a request is pending: old data dropped, target fetched.
        min_lat = 3; max_lat = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #2;
            if (imem.req && !imem.ack) found = 1'b1;
        end
        chk_eq("pending_found", 64'(found), 64'(1));
        old_addr = imem.addr;
        br_taken = 1'b1; br_addr = 30'h40;
        @(posedge clk); #2 br_taken = 1'b0;
        #1;
        chk_eq("br_bubble_en", 64'(if_en), 64'(0));
        chk_eq("br_bubble_insn", 64'(if_insn), 64'(NOP));
        chk_eq("drop_addr_kept", 64'(imem.addr), 64'(old_addr));
        wait_out(30'h40, 30, found);
        chk_eq("br_target_seen", 64'(found), 64'(1));

        // Branch with a same-cycle ack under stall: data discarded, skid empty.
        min_lat = 0; max_lat = 0;
        repeat (5) @(posedge clk);
        #2;
        chk_eq("ack_present", 64'(imem.ack), 64'(1));
        stall = 1'b1; br_taken = 1'b1; br_addr = 30'h123;
        @(posedge clk); #2 br_taken = 1'b0;
        #1;
        chk_eq("br_ack_en", 64'(if_en), 64'(0));
        chk_eq("br_ack_addr", 64'(imem.addr), 64'(30'h123));
        chk_eq("br_ack_req", 64'(imem.req), 64'(1));
        @(posedge clk); #2 stall = 1'b0;
        wait_out(30'h123, 10, found);
        chk_eq("br_ack_target_seen", 64'(found), 64'(1));

        // PC wrap at the top of the address space.
        min_lat = 0; max_lat = 2;
        @(posedge clk); #2 br_taken = 1'b1; br_addr = '1;
        @(posedge clk); #2 br_taken = 1'b0;
        wait_out('0, 40, found);
        chk_eq("wrap_to_zero", 64'(found), 64'(1));

        // Asynchronous reset in the middle of a wait, then a stray late ack.
        min_lat = 6; max_lat = 6;
        repeat (3) @(posedge clk);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #2;
            if (imem.req && !imem.ack) found = 1'b1;
        end
        chk_eq("midwait_found", 64'(found), 64'(1));
        #1 reset = 1'b0;
        #1 chk_reset_vals("async_reset");
        @(negedge clk) inject_ack = 1'b1;
        min_lat = 1; max_lat = 1;
        @(posedge clk); #2;
        reset = 1'b1; inject_ack = 1'b0;
        chk_eq("late_ack_visible", 64'(imem.ack), 64'(1));
        @(posedge clk); #3;
        chk_eq("restart_req", 64'(imem.req), 64'(1));
        chk_eq("restart_addr", 64'(imem.addr), 64'(RST_PC));
        wait_out(RST_PC, 10, found);
        chk_eq("restart_seen", 64'(found), 64'(1));
        chk_eq("restart_insn", 64'(if_insn), 64'(mem_word(RST_PC)));

        // Random traffic against the stream model.
        top = '1;
        for (int c = 0; c < 2500; c++) begin
            if (c % 200 == 0) begin
                min_lat = 0;
                max_lat = int'($urandom_range(3, 0));
            end
            @(posedge clk); #2;
            stall    = ($urandom_range(3, 0) == 0);
            br_taken = ($urandom_range(15, 0) == 0);
            r        = $urandom();
            br_addr  = ($urandom_range(3, 0) == 0) ? (top - PW'(r[1:0])) : r[PW-1:0];
        end
        @(posedge clk); #2 stall = 1'b0; br_taken = 1'b0;
        repeat (10) @(posedge clk);
        chk_eq("progress", 64'(consumed > 200), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
